// File: rtl/decode_dispatch_queue_if.sv
// Decode-to-rename handshake bundle: enqueue side from decode, dequeue side to rename.
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface decode_dispatch_queue_if #(
   parameter int MAX_OPERANDS = 3,
   parameter int ARN_BITS     = 6,
   parameter int FUC_BITS     = 2
);
   logic                                  in_valid;
   logic                                  in_ready;
   logic [31:0]                           in_raw_instr;
   logic [63:0]                           in_instr_pc;
   logic [FUC_BITS-1:0]                   in_fu_choice;
   logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] in_arn_inputs;
   logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] in_arn_outputs;

   logic                                  out_valid;
   logic                                  out_ready;
   logic [31:0]                           out_raw_instr;
   logic [63:0]                           out_instr_pc;
   logic [FUC_BITS-1:0]                   out_fu_choice;
   logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] out_arn_inputs;
   logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] out_arn_outputs;

   modport slave (
      input  in_valid, in_raw_instr, in_instr_pc, in_fu_choice, in_arn_inputs, in_arn_outputs,
      output in_ready,
      output out_valid, out_raw_instr, out_instr_pc, out_fu_choice, out_arn_inputs, out_arn_outputs,
      input  out_ready
   );

   modport master (
      output in_valid, in_raw_instr, in_instr_pc, in_fu_choice, in_arn_inputs, in_arn_outputs,
      input  in_ready,
      input  out_valid, out_raw_instr, out_instr_pc, out_fu_choice, out_arn_inputs, out_arn_outputs,
      output out_ready
   );
endinterface

// File: rtl/decode_dispatch_queue.sv
// First-word-fall-through queue between decode and rename, with stall gating on
// the read side and a flush that empties the queue and issues a one-cycle fetch redirect.
module decode_dispatch_queue #(
   parameter int DEPTH        = 8,
   parameter int MAX_OPERANDS = 3,
   parameter int ARN_BITS     = 6,
   parameter int FUC_BITS     = 2,
   parameter int AF_THRESH    = DEPTH - 2
) (
   input  logic                      clk,
   input  logic                      rst,
   decode_dispatch_queue_if.slave    q_if,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [63:0]               flush_pc,
   output logic                      set_pc_valid,
   output logic [63:0]               set_pc,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      almost_full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0]                           raw;
      logic [63:0]                           pc;
      logic [FUC_BITS-1:0]                   fu;
      logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] arn_in;
      logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] arn_out;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          wr_ent;
   entry_t          head;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            spv_q;
   logic            enq;
   logic            deq;

   // Full blocks enqueue outright, even when a dequeue happens in the same cycle.
   assign q_if.in_ready  = !rst && (count < CW'(DEPTH)) && !flush;
   assign q_if.out_valid = !rst && (count != '0) && !stall && !flush;
   assign enq            = q_if.in_valid && q_if.in_ready;
   assign deq            = q_if.out_valid && q_if.out_ready;
   assign almost_full    = !rst && (count >= CW'(AF_THRESH));
   assign set_pc_valid   = spv_q && !rst;

   assign wr_ent = '{raw:     q_if.in_raw_instr,
                     pc:      q_if.in_instr_pc,
                     fu:      q_if.in_fu_choice,
                     arn_in:  q_if.in_arn_inputs,
                     arn_out: q_if.in_arn_outputs};

   // Storage carries no reset; contents are only meaningful under out_valid.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= wr_ent;
   end

   assign head                 = mem[rd_ptr];
   assign q_if.out_raw_instr   = head.raw;
   assign q_if.out_instr_pc    = head.pc;
   assign q_if.out_fu_choice   = head.fu;
   assign q_if.out_arn_inputs  = head.arn_in;
   assign q_if.out_arn_outputs = head.arn_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         spv_q  <= 1'b0;
         set_pc <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         spv_q  <= 1'b1;
         set_pc <= flush_pc;
      end else begin
         spv_q <= 1'b0;
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(enq) - CW'(deq);
      end
   end
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Random and directed stimulus for decode_dispatch_queue, checked every cycle against a queue model.
module tb_decode_dispatch_queue;
   localparam int DEPTH = 8;
   localparam int MAX_OPERANDS = 3;
   localparam int ARN_BITS = 6;
   localparam int FUC_BITS = 2;
   localparam int AF_THRESH = DEPTH - 2;

   typedef struct packed {
      logic [31:0]                           raw;
      logic [63:0]                           pc;
      logic [FUC_BITS-1:0]                   fu;
      logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] ai;
      logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] ao;
   } ent_t;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       stall;
   logic                       flush;
   logic [63:0]                flush_pc;
   logic                       set_pc_valid;
   logic [63:0]                set_pc;
   logic [$clog2(DEPTH):0]     count;
   logic                       almost_full;

   decode_dispatch_queue_if #(.MAX_OPERANDS(MAX_OPERANDS), .ARN_BITS(ARN_BITS), .FUC_BITS(FUC_BITS)) qi ();

   decode_dispatch_queue #(
      .DEPTH(DEPTH), .MAX_OPERANDS(MAX_OPERANDS), .ARN_BITS(ARN_BITS),
      .FUC_BITS(FUC_BITS), .AF_THRESH(AF_THRESH)
   ) dut (
      .clk(clk), .rst(rst), .q_if(qi.slave), .stall(stall), .flush(flush),
      .flush_pc(flush_pc), .set_pc_valid(set_pc_valid), .set_pc(set_pc),
      .count(count), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   ent_t mq[$];
   logic spv_exp = 1'b0;
   logic [63:0] setpc_exp = '0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [63:0] pc);
      qi.in_valid     = v;
      qi.in_raw_instr = $urandom;
      qi.in_instr_pc  = pc;
      qi.in_fu_choice = FUC_BITS'($urandom);
      for (int i = 0; i < MAX_OPERANDS; i++) begin
         qi.in_arn_inputs[i]  = ARN_BITS'($urandom);
         qi.in_arn_outputs[i] = ARN_BITS'($urandom);
      end
   endtask

   // Check all outputs against the model, then advance the model by one edge.
   task automatic tick();
      logic e_ir, e_ov;
      ent_t obs, cur;
      @(negedge clk);
      e_ir = !rst && (mq.size() < DEPTH) && !flush;
      e_ov = !rst && (mq.size() > 0) && !stall && !flush;
      chk("in_ready", qi.in_ready, e_ir);
      chk("out_valid", qi.out_valid, e_ov);
      chk("count", count, mq.size());
      chk("almost_full", almost_full, !rst && (mq.size() >= AF_THRESH));
      chk("set_pc_valid", set_pc_valid, !rst && spv_exp);
      chk("set_pc", set_pc, setpc_exp);
      if (e_ov) begin
         obs = {qi.out_raw_instr, qi.out_instr_pc, qi.out_fu_choice, qi.out_arn_inputs, qi.out_arn_outputs};
         chk("head", obs, mq[0]);
      end
      cur = {qi.in_raw_instr, qi.in_instr_pc, qi.in_fu_choice, qi.in_arn_inputs, qi.in_arn_outputs};
      if (rst) begin
         mq.delete(); spv_exp = 1'b0; setpc_exp = '0;
      end else if (flush) begin
         mq.delete(); spv_exp = 1'b1; setpc_exp = flush_pc;
      end else begin
         spv_exp = 1'b0;
         if (e_ov && qi.out_ready) void'(mq.pop_front());
         if (e_ir && qi.in_valid) mq.push_back(cur);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_ctl();
      rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
   endtask

   task automatic drain();
      idle_ctl(); set_in(1'b0, '0); qi.out_ready = 1'b1;
      for (int i = 0; i < 4 * DEPTH && mq.size() > 0; i++) tick();
      chk("drain_done", count, 0);
   endtask

   task automatic fill(input int n);
      idle_ctl(); qi.out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         set_in(1'b1, {$urandom, $urandom});
         tick();
      end
      set_in(1'b0, '0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b1; flush_pc = 64'hdead;
      qi.out_ready = 1'b1; set_in(1'b1, 64'h55);
      @(posedge clk); #1;
      tick(); tick();

      // Fill to full with sequential PCs, then drain in order
      idle_ctl(); qi.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 64'h1000 + 64'(4 * i));
         tick();
      end
      chk("fill_count", count, DEPTH);
      chk("fill_in_ready", qi.in_ready, 0);
      tick();
      set_in(1'b0, '0); qi.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_pc", qi.out_instr_pc, 64'h1000 + 64'(4 * i));
         tick();
      end
      chk("drain_empty", count, 0);

      // Steady state at count 3 across pointer wrap
      fill(3);
      qi.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_in(1'b1, {$urandom, $urandom});
         tick();
      end
      chk("wrap_count", count, 3);
      drain();

      // Stall blocks dequeue only
      fill(4);
      stall = 1'b1; qi.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, {$urandom, $urandom});
         tick();
      end
      chk("stall_count", count, DEPTH);
      drain();

      // Flush drops the offered instruction and redirects fetch
      fill(5);
      flush = 1'b1; flush_pc = 64'h2000; set_in(1'b1, 64'h3000);
      tick();
      chk("flush_count", count, 0);
      chk("flush_spv", set_pc_valid, 1);
      chk("flush_setpc", set_pc, 64'h2000);
      flush = 1'b0; set_in(1'b0, '0);
      tick();

      // Back-to-back flushes each produce their own pulse
      for (int i = 0; i < 3; i++) begin
         flush = 1'b1; flush_pc = 64'h4000 + 64'(i * 16); set_in(1'b1, '1);
         tick();
      end
      flush = 1'b0; set_in(1'b0, '0);
      tick(); tick();

      // Full with a dequeue: no pass-through
      fill(DEPTH);
      qi.out_ready = 1'b1; set_in(1'b1, 64'h7777);
      tick();
      chk("full_deq_count", count, DEPTH - 1);
      drain();

      // Reset during flush suppresses the redirect
      fill(6);
      rst = 1'b1; flush = 1'b1; flush_pc = 64'h9000;
      tick();
      idle_ctl();
      tick();
      chk("rst_spv", set_pc_valid, 0);
      chk("rst_count", count, 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst          = ($urandom % 300) == 0;
         stall        = ($urandom % 6) == 0;
         flush        = ($urandom % 40) == 0;
         flush_pc     = {$urandom, $urandom};
         qi.out_ready = ($urandom % 3) != 0;
         set_in(($urandom % 4) != 0, {$urandom, $urandom});
         tick();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/decode_dispatch_queue.md
DECODE_DISPATCH_QUEUE -- requirements
Module: decode_dispatch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the queue entry count (power of two, at least 2).
REQ-002 The block SHALL have parameter MAX_OPERANDS, default 3, giving operand slots per instruction.
REQ-003 The block SHALL have parameter ARN_BITS, default 6, giving the architectural register number width.
REQ-004 The block SHALL have parameter FUC_BITS, default 2, giving the functional-unit choice width.
REQ-005 The block SHALL have parameter AF_THRESH, default DEPTH-2, giving the almost-full level.
REQ-006 The block SHALL have one clock and a synchronous active-high reset, with ports listed as follows:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  decoded instruction offered
- in_ready  output  1  queue accepts instruction
- in_raw_instr  input  32  instruction word
- in_instr_pc  input  64  instruction PC
- in_fu_choice  input  FUC_BITS  target FU
- in_arn_inputs  input  MAX_OPERANDS x ARN_BITS  source ARNs
- in_arn_outputs  input  MAX_OPERANDS x ARN_BITS  destination ARNs
- stall  input  1  rename stall from ROB
- flush  input  1  discard all queued instructions
- flush_pc  input  64  redirect target
- set_pc_valid  output  1  fetch redirect pulse
- set_pc  output  64  fetch redirect PC
- out_valid  output  1  head instruction offered to rename
- out_ready  input  1  rename accepts head
- out_raw_instr, out_instr_pc, out_fu_choice, out_arn_inputs, out_arn_outputs  output  same widths as inputs  head entry fields
- count  output  clog2(DEPTH)+1  occupied entries
- almost_full  output  1  count >= AF_THRESH

Function
REQ-007 Enqueue SHALL occur on a cycle with in_valid and in_ready both high; in_ready SHALL equal (count < DEPTH) and not flush.
REQ-008 Dequeue SHALL occur on a cycle with out_valid and out_ready both high; out_valid SHALL equal (count > 0), not stall, and not flush.
REQ-009 Out_* data SHALL come combinationally from the head entry (first-word fall-through); it SHALL hold stable while out_valid is high and out_ready is low.
REQ-010 Latency SHALL be one cycle: an instruction enqueued at edge N into an empty queue is visible with out_valid high after edge N; there is no same-cycle bypass.
REQ-011 Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL be kept separately, giving unambiguous full and empty.
REQ-012 A simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-013 When full, in_ready SHALL be low even if a dequeue occurs in the same cycle; there is no full pass-through.
REQ-014 Stall SHALL block dequeue only; enqueue continues until full.
REQ-015 On flush, at the next edge count and both pointers SHALL go to 0, and any in_valid offered that cycle SHALL be dropped.
REQ-016 On flush, the cycle after the flush cycle SHALL have set_pc_valid=1 and set_pc=flush_pc for exactly one cycle.
REQ-017 A flush held for consecutive cycles SHALL produce one set_pc_valid pulse per flush cycle, each carrying that cycle's flush_pc.
REQ-018 Flush SHALL take priority over stall, enqueue and dequeue.
REQ-019 Almost_full SHALL be combinational from count.

Reset
REQ-020 At the first edge with rst=1, the block SHALL clear count, pointers, set_pc_valid and set_pc.
REQ-021 While in reset, in_ready, out_valid, almost_full and set_pc_valid SHALL all be 0.
REQ-022 Reset SHALL override flush; no set_pc_valid pulse SHALL follow a flush that coincides with reset.
REQ-023 Entry storage SHALL need no reset; out_* data SHALL be don't-care while out_valid=0.

Verification
REQ-024 Fill/drain: DEPTH=8, out_ready=0, enqueue pc 0x1000..0x101C -> count=8, in_ready=0, almost_full=1 from count=6; then out_ready=1 -> PCs emerge in order, one per cycle, and count reaches 0.
REQ-025 Wrap: 20 back-to-back enqueue/dequeue pairs with count held at 3 -> count stays 3 and output order is preserved across pointer wrap.
REQ-026 Stall: count=4, stall=1 for 5 cycles with out_ready=1 -> out_valid=0 and no dequeue; enqueue continues until count=8; after stall drops, all entries are dequeued in order.
REQ-027 Flush: count=5, flush=1 with flush_pc=0x2000 and in_valid=1 -> next cycle count=0, set_pc_valid=1, set_pc=0x2000, and the offered instruction is absent.
REQ-028 Full with dequeue: count=8, out_ready=1, in_valid=1 -> in_ready=0, and count=7 after the edge.
REQ-029 Reset mid-operation: count=6, rst=1 for one cycle together with flush=1 -> count=0, out_valid=0, and set_pc_valid stays 0.
